// File: rtl/nanorv32_timer_resp.sv
// Memory-mapped timer responder on the nanorv32 data port: CTRL/COUNT/COMPARE/STATUS, compare-match irq.
// Latency: ack 1+WAIT_STATES cycles after a request is accepted in IDLE; one access per 2+WAIT_STATES cycles.
// Backpressure: the CPU holds req until ack; requests are not sampled during WAIT/ACK, out-of-window requests are ignored.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   cpu_datamem_req/addr/wdata     access request, byte address, write data
//   cpu_datamem_bytesel            byte-lane write enables (0 = read)
//   datamem_cpu_ack/rdata          one-cycle completion pulse, read data (0 when ack low)
//   timer_irq                      level interrupt = STATUS.MATCH & CTRL.IE
module nanorv32_timer_resp #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_datamem_req,
    input  logic [31:0] cpu_datamem_addr,
    input  logic [31:0] cpu_datamem_wdata,
    input  logic [3:0]  cpu_datamem_bytesel,
    output logic        datamem_cpu_ack,
    output logic [31:0] datamem_cpu_rdata,
    output logic        timer_irq
);

    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        sel;
    logic        accept;
    logic [1:0]  acc_off;
    logic [31:0] acc_wdat;
    logic [3:0]  acc_bsel;
    logic [3:0]  wait_cnt;

    logic [2:0]  ctrl;        // bit0 EN, bit1 IE, bit2 AUTO_RELOAD
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;

    logic        hit;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_cmp;
    logic        w1c;
    logic [31:0] reg_rd;

    // Word offset only; the byte offset within a word has no meaning here.
    logic [1:0]  unused_addr_lsb;
    assign unused_addr_lsb = cpu_datamem_addr[1:0];

    function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wd[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

    assign sel    = (cpu_datamem_addr[31:4] == BASE_ADDR[31:4]);
    assign accept = (state == ST_IDLE) && cpu_datamem_req && sel;

    // ---------------- responder FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        datamem_cpu_ack   = (state == ST_ACK);
        datamem_cpu_rdata = (state == ST_ACK) ? reg_rd : 32'd0;
    end

    // Request capture and wait-state counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_off  <= 2'd0;
            acc_wdat <= 32'd0;
            acc_bsel <= 4'd0;
            wait_cnt <= 4'd0;
        end else if (accept) begin
            acc_off  <= cpu_datamem_addr[3:2];
            acc_wdat <= cpu_datamem_wdata;
            acc_bsel <= cpu_datamem_bytesel;
            wait_cnt <= WAIT_INIT;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // ---------------- register file ----------------
    always_comb begin
        reg_rd = 32'd0;
        case (acc_off)
            2'd0: reg_rd = {29'd0, ctrl};
            2'd1: reg_rd = count;
            2'd2: reg_rd = compare;
            2'd3: reg_rd = {31'd0, match};
            default: reg_rd = 32'd0;
        endcase
    end

    // Writes commit on the edge that ends the ACK cycle.
    assign wr       = (state == ST_ACK) && (acc_bsel != 4'd0);
    assign wr_ctrl  = wr && (acc_off == 2'd0) && acc_bsel[0];
    assign wr_count = wr && (acc_off == 2'd1);
    assign wr_cmp   = wr && (acc_off == 2'd2);
    assign w1c      = wr && (acc_off == 2'd3) && acc_bsel[0] && acc_wdat[0];

    assign hit = ctrl[0] && (count == compare);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl    <= 3'd0;
            count   <= 32'd0;
            compare <= 32'hFFFF_FFFF;
            match   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= acc_wdat[2:0];
            end

            // CPU write beats reload, reload beats increment.
            if (wr_count) begin
                count <= lane_merge(count, acc_wdat, acc_bsel);
            end else if (hit && ctrl[2]) begin
                count <= 32'd0;
            end else if (ctrl[0]) begin
                count <= count + 32'd1;
            end

            if (wr_cmp) begin
                compare <= lane_merge(compare, acc_wdat, acc_bsel);
            end

            // A fresh match wins over a simultaneous clear so no event is lost.
            if (hit) begin
                match <= 1'b1;
            end else if (w1c) begin
                match <= 1'b0;
            end
        end
    end

    assign timer_irq = match & ctrl[1];

endmodule

// File: tb/tb_nanorv32_timer_resp.sv
module tb_nanorv32_timer_resp;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] OFF_CTRL = 32'h0;
    localparam logic [31:0] OFF_CNT  = 32'h4;
    localparam logic [31:0] OFF_CMP  = 32'h8;
    localparam logic [31:0] OFF_STAT = 32'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bytesel;
    int          dsel;   // equals WAIT_STATES of the addressed instance

    logic        req0, req1, req3;
    logic        ack0, ack1, ack3;
    logic [31:0] rdata0, rdata1, rdata3;
    logic        irq0, irq1, irq3;
    logic        ack;
    logic [31:0] rdata;
    logic        irq;

    always #5 clk = ~clk;

    assign req0 = req && (dsel == 0);
    assign req1 = req && (dsel == 1);
    assign req3 = req && (dsel == 3);

    always_comb begin
        ack   = ack1;
        rdata = rdata1;
        irq   = irq1;
        if (dsel == 0) begin
            ack = ack0; rdata = rdata0; irq = irq0;
        end else if (dsel == 3) begin
            ack = ack3; rdata = rdata3; irq = irq3;
        end
    end

    nanorv32_timer_resp #(.BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cpu_datamem_req(req0), .cpu_datamem_addr(addr),
        .cpu_datamem_wdata(wdata), .cpu_datamem_bytesel(bytesel),
        .datamem_cpu_ack(ack0), .datamem_cpu_rdata(rdata0), .timer_irq(irq0));

    nanorv32_timer_resp #(.BASE_ADDR(BASE), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cpu_datamem_req(req1), .cpu_datamem_addr(addr),
        .cpu_datamem_wdata(wdata), .cpu_datamem_bytesel(bytesel),
        .datamem_cpu_ack(ack1), .datamem_cpu_rdata(rdata1), .timer_irq(irq1));

    nanorv32_timer_resp #(.BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cpu_datamem_req(req3), .cpu_datamem_addr(addr),
        .cpu_datamem_wdata(wdata), .cpu_datamem_bytesel(bytesel),
        .datamem_cpu_ack(ack3), .datamem_cpu_rdata(rdata3), .timer_irq(irq3));

    typedef struct {
        logic [31:0] exp;
        bit          rd;
        int          lat;
        int          issue;
        int          id;
    } sb_t;

    sb_t sbq[$];
    int  checks  = 0;
    int  errors  = 0;
    int  cyc     = 0;
    int  ack_cnt = 0;
    int  next_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expectation per ack and checks latency and read data.
    always @(negedge clk) begin : monitor
        sb_t e;
        if (ack) begin
            ack_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: ack at cycle %0d with no access outstanding (dut ws=%0d)", cyc, dsel);
            end else begin
                e = sbq.pop_front();
                checks++;
                if (cyc - e.issue != e.lat) begin
                    errors++;
                    $display("FAIL latency #%0d: got %0d cycles, expected %0d", e.id, cyc - e.issue, e.lat);
                end
                if (e.rd) begin
                    checks++;
                    if (rdata !== e.exp) begin
                        errors++;
                        $display("FAIL rdata #%0d: got %08h, expected %08h", e.id, rdata, e.exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp);
        sb_t e;
        bit  got;
        @(posedge clk);
        #1;
        dsel    = d;
        addr    = a;
        wdata   = wd;
        bytesel = be;
        req     = 1'b1;
        e.exp   = exp;
        e.rd    = (be == 4'd0);
        e.lat   = d + 1;
        e.issue = cyc;
        e.id    = next_id;
        next_id++;
        sbq.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout #%0d: no ack within 40 cycles, expected after %0d", e.id, e.lat);
            sbq.delete(sbq.size() - 1);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic wr(input int d, input logic [31:0] off, input logic [31:0] wd, input logic [3:0] be);
        access(d, BASE + off, wd, be, 32'd0);
    endtask

    task automatic rd(input int d, input logic [31:0] off, input logic [31:0] exp);
        access(d, BASE + off, 32'd0, 4'd0, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        req     = 1'b0;
        addr    = 32'd0;
        wdata   = 32'd0;
        bytesel = 4'd0;
        dsel    = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", {31'd0, ack}, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;

        // Reset values, 2-cycle latency
        rd(1, OFF_CTRL, 32'd0);
        rd(1, OFF_CNT,  32'd0);
        rd(1, OFF_CMP,  32'hFFFF_FFFF);
        rd(1, OFF_STAT, 32'd0);

        // Wait states 0 and 3
        wr(0, OFF_CMP, 32'h1234_5678, 4'hF);
        rd(0, OFF_CMP, 32'h1234_5678);
        wr(3, OFF_CMP, 32'h1234_5678, 4'hF);
        rd(3, OFF_CMP, 32'h1234_5678);

        // Byte lanes on COUNT with EN=0
        wr(1, OFF_CNT, 32'hAABB_CCDD, 4'hF);
        wr(1, OFF_CNT, 32'h1122_3344, 4'b0101);
        rd(1, OFF_CNT, 32'hAA22_CC44);

        // Match + auto reload, period 6: count in cycle A+1+k is k mod 6
        wr(1, OFF_CNT,  32'd0, 4'hF);
        wr(1, OFF_CMP,  32'd5, 4'hF);
        wr(1, OFF_CTRL, 32'd7, 4'hF);      // ack in cycle A
        rd(1, OFF_CNT,  32'd3);            // ack A+4
        rd(1, OFF_CNT,  32'd1);            // ack A+8
        rd(1, OFF_STAT, 32'd1);            // ack A+12
        chk("irq_after_match", {31'd0, irq}, 32'd1);

        // Plain W1C with counter stopped
        wr(1, OFF_CTRL, 32'd2, 4'hF);
        wr(1, OFF_STAT, 32'd1, 4'b0001);
        rd(1, OFF_STAT, 32'd0);
        chk("irq_after_clear", {31'd0, irq}, 32'd0);

        // W1C colliding with a match: count 97 at B+1 reaches 100 at B+4
        wr(1, OFF_CMP,  32'd100, 4'hF);
        wr(1, OFF_CNT,  32'd97, 4'hF);
        wr(1, OFF_CTRL, 32'd3, 4'hF);      // ack B
        wr(1, OFF_STAT, 32'd1, 4'b0001);   // ack B+4
        rd(1, OFF_STAT, 32'd1);            // ack B+8
        chk("irq_clear_vs_match", {31'd0, irq}, 32'd1);
        rd(1, OFF_CNT,  32'd108);          // ack B+12, no reload

        // Wrap: FFFFFFFE at C+1, 3 at C+6, MATCH from C+7
        wr(1, OFF_CTRL, 32'd0, 4'hF);
        wr(1, OFF_CMP,  32'd3, 4'hF);
        wr(1, OFF_STAT, 32'd1, 4'hF);
        wr(1, OFF_CNT,  32'hFFFF_FFFE, 4'hF);
        wr(1, OFF_CTRL, 32'd3, 4'hF);      // ack C
        rd(1, OFF_STAT, 32'd0);            // ack C+4, count 1
        rd(1, OFF_CNT,  32'd5);            // ack C+8
        rd(1, OFF_STAT, 32'd1);            // ack C+12

        // Outside the window: no ack
        n = ack_cnt;
        @(posedge clk);
        #1;
        dsel = 1; addr = BASE + 32'h20; wdata = 32'd0; bytesel = 4'hF; req = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        req = 1'b0;
        chk("no_ack_outside", ack_cnt, n);

        // Reset during WAIT: write to COMPARE must be lost
        @(posedge clk);
        #1;
        dsel = 1; addr = BASE + OFF_CMP; wdata = 32'hDEAD_BEEF; bytesel = 4'hF; req = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = 1'b0;
        n = ack_cnt;
        repeat (4) @(posedge clk);
        #1;
        chk("midreset_irq", {31'd0, irq}, 32'd0);
        chk("midreset_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_no_ack", ack_cnt, n);
        rd(1, OFF_CMP,  32'hFFFF_FFFF);
        rd(1, OFF_CTRL, 32'd0);

        // CTRL upper bits read as zero
        wr(1, OFF_CTRL, 32'hFFFF_FFFA, 4'hF);
        rd(1, OFF_CTRL, 32'd2);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
